pdm_mic_deserializer: RTL and testbench



---
 rtl/pdm_mic_deserializer_pkg.sv | 9 +
 rtl/pdm_clock_gen.sv | 45 ++++
 rtl/pdm_mic_deserializer.sv | 98 +++++++++
 tb/tb_pdm_mic_deserializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_mic_deserializer_pkg.sv
// Shared audio constants: system clock rate and the 10-bit duty-cycle sample scale
// common to the PDM capture path and the PWM serializer.
package pdm_mic_deserializer_pkg;
    localparam int SYSTEM_FREQ      = 25_000_000;
    localparam int AUDIO_SAMPLE_W   = 10;
    localparam int AUDIO_SAMPLE_MAX = 1023;

    typedef logic [AUDIO_SAMPLE_W-1:0] audio_sample_t;
endpackage

// File: rtl/pdm_clock_gen.sv
// Mic clock divider: micClk toggles every CLK_HALF clk; bit_stb is a same-cycle pulse
// on the last high cycle (micClk about to fall). No backpressure; enable low parks micClk at 0.
module pdm_clock_gen #(
    parameter int CLK_HALF = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic micClk,
    output logic bit_stb
);
    localparam int DIV_W = $clog2(CLK_HALF);

    logic [DIV_W-1:0] div_q, div_d;
    logic             mic_clk_q, mic_clk_d;
    logic             terminal;

    assign terminal = (div_q == DIV_W'(CLK_HALF - 1));

    always_comb begin
        div_d     = div_q + 1'b1;
        mic_clk_d = mic_clk_q;
        if (!enable) begin
            div_d     = '0;
            mic_clk_d = 1'b0;
        end else if (terminal) begin
            div_d     = '0;
            mic_clk_d = ~mic_clk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign micClk  = mic_clk_q;
    // Mic data is stable at the end of the high phase, just before the falling edge.
    assign bit_stb = enable && terminal && mic_clk_q;
endmodule

// File: rtl/pdm_mic_deserializer.sv
// PDM mic capture: counts ones over 2^WINDOW_LOG2 bits into a 0..1023 sample; valid one clk
// after the window's last strobe. Holding register with valid/ready; overwrite sets sticky overrun.
module pdm_mic_deserializer
    import pdm_mic_deserializer_pkg::*;
#(
    parameter int CLK_HALF    = 5,
    parameter int WINDOW_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      micData,
    output logic                      micClk,
    output logic                      micLRSel,
    output logic [AUDIO_SAMPLE_W-1:0] sample,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      overrun
);
    localparam int EXT_W = WINDOW_LOG2 + 12;
    localparam int SHL   = (WINDOW_LOG2 < AUDIO_SAMPLE_W) ? AUDIO_SAMPLE_W - WINDOW_LOG2 : 0;
    localparam int SHR   = (WINDOW_LOG2 > AUDIO_SAMPLE_W) ? WINDOW_LOG2 - AUDIO_SAMPLE_W : 0;

    logic [1:0]             sync_q;
    logic                   mic_data_s;
    logic                   bit_stb;
    logic                   last_bit;
    logic [WINDOW_LOG2-1:0] bit_cnt_q, bit_cnt_d;
    logic [WINDOW_LOG2:0]   ones_q, ones_d;
    logic [WINDOW_LOG2:0]   total;
    logic [EXT_W-1:0]       scaled;
    audio_sample_t          sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    pdm_clock_gen #(.CLK_HALF(CLK_HALF)) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .micClk (micClk),
        .bit_stb(bit_stb)
    );

    assign mic_data_s = sync_q[1];
    assign last_bit   = bit_stb && (bit_cnt_q == '1);
    assign total      = ones_q + (WINDOW_LOG2 + 1)'(mic_data_s);
    assign scaled     = ({{11{1'b0}}, total} << SHL) >> SHR;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (!enable) begin
            bit_cnt_d = '0;
            ones_d    = '0;
        end else if (bit_stb) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ones_d    = last_bit ? '0 : total;
        end

        // A completing window wins over a consume, so valid stays high with the new value.
        if (last_bit) begin
            sample_d = (scaled > EXT_W'(AUDIO_SAMPLE_MAX)) ? AUDIO_SAMPLE_W'(AUDIO_SAMPLE_MAX)
                                                            : scaled[AUDIO_SAMPLE_W-1:0];
            valid_d  = 1'b1;
            if (valid_q && !sample_ready)
                overrun_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], micData};
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign micLRSel     = 1'b0;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_pdm_mic_deserializer.sv
// Directed bench for pdm_mic_deserializer: a 1024-bit-window instance and a 16-bit-window
// instance share one clock; each scenario task checks its own hand-computed expectations.
module tb_pdm_mic_deserializer;
    logic       clk = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       rst10 = 1'b1, en10 = 1'b0, rdy10 = 1'b0;
    logic       const10 = 1'b0, alt10 = 1'b0, tgl10 = 1'b0;
    logic       md10, mclk10, lr10, vld10, ovr10;
    logic [9:0] smp10;

    logic       rst4 = 1'b1, en4 = 1'b0, rdy4 = 1'b0;
    logic       const4 = 1'b0, alt4 = 1'b0, tgl4 = 1'b0;
    logic       md4, mclk4, lr4, vld4, ovr4;
    logic [9:0] smp4;

    always #20 clk = ~clk;

    // Microphone model: alternate pattern flips once per mic clock period on the rising edge.
    always @(posedge mclk10) tgl10 = ~tgl10;
    always @(posedge mclk4)  tgl4  = ~tgl4;
    assign md10 = alt10 ? tgl10 : const10;
    assign md4  = alt4  ? tgl4  : const4;

    pdm_mic_deserializer dut (
        .clk(clk), .reset(rst10), .enable(en10), .micData(md10), .micClk(mclk10),
        .micLRSel(lr10), .sample(smp10), .sample_valid(vld10), .sample_ready(rdy10),
        .overrun(ovr10)
    );

    pdm_mic_deserializer #(.CLK_HALF(5), .WINDOW_LOG2(4)) dut4 (
        .clk(clk), .reset(rst4), .enable(en4), .micData(md4), .micClk(mclk4),
        .micLRSel(lr4), .sample(smp4), .sample_valid(vld4), .sample_ready(rdy4),
        .overrun(ovr4)
    );

    task automatic reset10();
        rst10 = 1'b1;
        repeat (3) @(negedge clk);
        rst10 = 1'b0;
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        repeat (3) @(negedge clk);
        rst4 = 1'b0;
    endtask

    task automatic wait_valid10(input int budget, output int cyc);
        cyc = 0;
        while (vld10 !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_valid4(input int budget, output int cyc);
        cyc = 0;
        while (vld4 !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst10 = 1'b1; rst4 = 1'b1; en10 = 1'b1; en4 = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (mclk10 !== 1'b0) begin n_bad++; $display("FAIL reset_micclk10 got=%b want=0", mclk10); end
        n_cmp++; if (smp10 !== 10'd0) begin n_bad++; $display("FAIL reset_sample10 got=%0d want=0", smp10); end
        n_cmp++; if (vld10 !== 1'b0) begin n_bad++; $display("FAIL reset_valid10 got=%b want=0", vld10); end
        n_cmp++; if (ovr10 !== 1'b0) begin n_bad++; $display("FAIL reset_overrun10 got=%b want=0", ovr10); end
        n_cmp++; if (lr10 !== 1'b0) begin n_bad++; $display("FAIL reset_lrsel10 got=%b want=0", lr10); end
        n_cmp++; if ({mclk4, smp4, vld4, ovr4, lr4} !== 14'd0) begin
            n_bad++; $display("FAIL reset_outputs4 got=%b want=0", {mclk4, smp4, vld4, ovr4, lr4});
        end
    endtask

    task automatic test_clock();
        int bad_clk = 0, bad_stb = 0, bad_lr = 0;
        logic exp_clk, exp_stb;
        en10 = 1'b1;
        reset10();
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            exp_clk = ((k / 5) % 2) == 1;
            exp_stb = exp_clk && ((k % 5) == 4);
            if (mclk10 !== exp_clk) bad_clk++;
            if (dut.u_clk_gen.bit_stb !== exp_stb) bad_stb++;
            if (lr10 !== 1'b0) bad_lr++;
        end
        n_cmp++; if (bad_clk != 0) begin n_bad++; $display("FAIL clock_waveform bad_cycles=%0d want=0", bad_clk); end
        n_cmp++; if (bad_stb != 0) begin n_bad++; $display("FAIL clock_strobe bad_cycles=%0d want=0", bad_stb); end
        n_cmp++; if (bad_lr != 0) begin n_bad++; $display("FAIL clock_lrsel bad_cycles=%0d want=0", bad_lr); end
    endtask

    task automatic test_full_scale();
        int cyc;
        const10 = 1'b1; alt10 = 1'b0; rdy10 = 1'b1; en10 = 1'b1;
        reset10();
        wait_valid10(10300, cyc);
        n_cmp++; if (cyc !== 10240) begin n_bad++; $display("FAIL full_first_latency got=%0d want=10240", cyc); end
        n_cmp++; if (smp10 !== 10'd1023) begin n_bad++; $display("FAIL full_sample1 got=%0d want=1023", smp10); end
        @(negedge clk);
        n_cmp++; if (vld10 !== 1'b0) begin n_bad++; $display("FAIL full_consumed got=%b want=0", vld10); end
        wait_valid10(10300, cyc);
        n_cmp++; if (cyc + 1 !== 10240) begin n_bad++; $display("FAIL full_spacing got=%0d want=10240", cyc + 1); end
        n_cmp++; if (smp10 !== 10'd1023) begin n_bad++; $display("FAIL full_sample2 got=%0d want=1023", smp10); end
    endtask

    task automatic test_half_scale();
        int cyc;
        alt10 = 1'b1; rdy10 = 1'b1; en10 = 1'b1;
        alt4 = 1'b1; rdy4 = 1'b1; en4 = 1'b1;
        reset10();
        wait_valid10(10300, cyc);
        n_cmp++; if (smp10 !== 10'd512 || vld10 !== 1'b1) begin
            n_bad++; $display("FAIL half_sample10 got=%0d valid=%b want=512 valid=1", smp10, vld10);
        end
        alt10 = 1'b0;
        reset4();
        wait_valid4(200, cyc);
        n_cmp++; if (smp4 !== 10'd512 || vld4 !== 1'b1) begin
            n_bad++; $display("FAIL half_sample4 got=%0d valid=%b want=512 valid=1", smp4, vld4);
        end
        alt4 = 1'b0;
    endtask

    task automatic test_zero_scale();
        int cyc;
        const4 = 1'b1; rdy4 = 1'b1; en4 = 1'b1;
        reset4();
        wait_valid4(200, cyc);
        n_cmp++; if (cyc !== 160) begin n_bad++; $display("FAIL w4_latency got=%0d want=160", cyc); end
        n_cmp++; if (smp4 !== 10'd1023) begin n_bad++; $display("FAIL w4_saturate got=%0d want=1023", smp4); end
        const4 = 1'b0;
        @(negedge clk);
        wait_valid4(200, cyc);
        n_cmp++; if (cyc !== 159) begin n_bad++; $display("FAIL zero_spacing got=%0d want=159", cyc); end
        n_cmp++; if (smp4 !== 10'd0) begin n_bad++; $display("FAIL zero_sample got=%0d want=0", smp4); end
    endtask

    task automatic test_overrun();
        int cyc;
        const4 = 1'b1; rdy4 = 1'b0; en4 = 1'b1;
        reset4();
        wait_valid4(200, cyc);
        n_cmp++; if (smp4 !== 10'd1023 || ovr4 !== 1'b0) begin
            n_bad++; $display("FAIL ovr_first got=%0d ovr=%b want=1023 ovr=0", smp4, ovr4);
        end
        const4 = 1'b0;
        cyc = 0;
        while (ovr4 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 160) begin n_bad++; $display("FAIL ovr_timing got=%0d want=160", cyc); end
        n_cmp++; if (smp4 !== 10'd0 || vld4 !== 1'b1) begin
            n_bad++; $display("FAIL ovr_overwrite got=%0d valid=%b want=0 valid=1", smp4, vld4);
        end
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        n_cmp++; if (vld4 !== 1'b0 || ovr4 !== 1'b1) begin
            n_bad++; $display("FAIL ovr_sticky valid=%b ovr=%b want valid=0 ovr=1", vld4, ovr4);
        end
    endtask

    task automatic test_same_cycle();
        int cyc;
        const4 = 1'b1; rdy4 = 1'b0; en4 = 1'b1;
        reset4();
        n_cmp++; if (ovr4 !== 1'b0) begin n_bad++; $display("FAIL same_reset_ovr got=%b want=0", ovr4); end
        wait_valid4(200, cyc);
        const4 = 1'b0;
        repeat (159) @(negedge clk);
        n_cmp++; if (vld4 !== 1'b1 || smp4 !== 10'd1023) begin
            n_bad++; $display("FAIL same_hold got=%0d valid=%b want=1023 valid=1", smp4, vld4);
        end
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        n_cmp++; if (vld4 !== 1'b1 || smp4 !== 10'd0 || ovr4 !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle got=%0d valid=%b ovr=%b want=0 valid=1 ovr=0", smp4, vld4, ovr4);
        end
    endtask

    task automatic test_enable_mid();
        int cyc, bad_clk = 0, bad_vld = 0;
        const10 = 1'b1; alt10 = 1'b0; rdy10 = 1'b1; en10 = 1'b1;
        reset10();
        repeat (5005) @(negedge clk);
        en10 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mclk10 !== 1'b0) bad_clk++;
            if (vld10 !== 1'b0) bad_vld++;
        end
        n_cmp++; if (bad_clk != 0) begin n_bad++; $display("FAIL disable_micclk bad_cycles=%0d want=0", bad_clk); end
        n_cmp++; if (bad_vld != 0) begin n_bad++; $display("FAIL disable_valid bad_cycles=%0d want=0", bad_vld); end
        en10 = 1'b1;
        wait_valid10(10300, cyc);
        n_cmp++; if (cyc !== 10240) begin n_bad++; $display("FAIL reenable_latency got=%0d want=10240", cyc); end
        n_cmp++; if (smp10 !== 10'd1023) begin n_bad++; $display("FAIL reenable_sample got=%0d want=1023", smp10); end
    endtask

    task automatic test_reset_mid();
        int bad_vld = 0;
        repeat (3000) @(negedge clk);
        n_cmp++; if (smp10 !== 10'd1023) begin n_bad++; $display("FAIL pre_reset_sample got=%0d want=1023", smp10); end
        rst10 = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mclk10, smp10, vld10, ovr10} !== 13'd0) begin
            n_bad++; $display("FAIL midreset_outputs got=%b want=0", {mclk10, smp10, vld10, ovr10});
        end
        rst10 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vld10 !== 1'b0) bad_vld++;
        end
        n_cmp++; if (bad_vld != 0) begin n_bad++; $display("FAIL midreset_spurious_valid cycles=%0d want=0", bad_vld); end
    endtask

    initial begin
        test_reset();
        test_clock();
        test_full_scale();
        test_half_scale();
        test_zero_scale();
        test_overrun();
        test_same_cycle();
        test_enable_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
